// File: rtl/integrator_seq_ctrl.sv
// Sequencing controller for one channel's moving-integrator filter.
// After every (re)start it zero-flushes the filter window, counts samples
// through warmup, then qualifies the filter output once window and
// pipeline are full.
//
// state  | meaning
// IDLE   | channel disabled, filter held in reset
// FLUSH  | filter reset (phase A), then zeros clocked through window (phase B)
// WARMUP | real samples fill window and pipeline, output not yet valid
// RUN    | samples pass through, every filter update yields a valid y_out
module integrator_seq_ctrl #(
  parameter int K        = 25,
  parameter int PIPE_LAT = 3,
  parameter int RST_CYC  = 2,
  parameter int DW       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ch_enable,
  input  logic                 restart,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] filt_y,
  output logic                 filt_reset,
  output logic                 filt_enable,
  output logic signed [DW-1:0] filt_x,
  output logic signed [DW-1:0] y_out,
  output logic                 y_valid,
  output logic                 ready,
  output logic [1:0]           state,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_WARMUP = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam int CW = 8;
  // Last counter value of FLUSH (phase A + K+2 zero writes) and of WARMUP
  // (K window samples + PIPE_LAT pipeline samples).
  localparam logic [CW-1:0] RST_LEN    = CW'(RST_CYC);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(RST_CYC + K + 1);
  localparam logic [CW-1:0] WARM_LAST  = CW'(K + PIPE_LAT - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 filt_reset_d, filt_enable_d, y_valid_d, ready_d;
  logic signed [DW-1:0] filt_x_d;
  logic                 pass;

  assign state = state_q;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      filt_reset  <= 1'b1;
      filt_enable <= 1'b0;
      filt_x      <= '0;
      y_out       <= '0;
      y_valid     <= 1'b0;
      ready       <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_reset  <= filt_reset_d;
      filt_enable <= filt_enable_d;
      filt_x      <= filt_x_d;
      y_valid     <= y_valid_d;
      ready       <= ready_d;
      if (y_valid_d) begin
        y_out <= filt_y;
      end
      if ((state_q == S_FLUSH) && sample_valid && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Next-state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (ch_enable) begin
        state_d = S_FLUSH;
        cnt_d   = '0;
      end
    end else if (!ch_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (restart) begin
      state_d = S_FLUSH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_d = S_WARMUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WARMUP: begin
          if (sample_valid) begin
            if (cnt_q == WARM_LAST) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the state being entered
  always_comb begin
    // Samples reach the filter only while staying within WARMUP/RUN; a sample
    // arriving on a restart or disable cycle is superseded by the flush.
    pass = ((state_q == S_WARMUP) || (state_q == S_RUN)) &&
           ((state_d == S_WARMUP) || (state_d == S_RUN));
    filt_reset_d  = (state_d == S_IDLE) ||
                    ((state_d == S_FLUSH) && (cnt_d < RST_LEN));
    filt_enable_d = ((state_d == S_FLUSH) && (cnt_d >= RST_LEN)) ||
                    (pass && sample_valid);
    filt_x_d      = pass ? x_in : '0;
    y_valid_d     = (state_q == S_RUN) && (state_d == S_RUN) && filt_enable;
    ready_d       = (state_d == S_RUN);
  end

endmodule

// File: tb/tb_integrator_seq_ctrl.sv
// Self-checking bench for integrator_seq_ctrl. Expected filter inputs and
// qualified outputs are queued with their due step when stimulus is driven
// and compared when the step arrives.
module tb_integrator_seq_ctrl;
  localparam int K         = 25;
  localparam int PIPE_LAT  = 3;
  localparam int RST_CYC   = 2;
  localparam int DW        = 16;
  localparam int FLUSH_CYC = RST_CYC + K + 2;
  localparam int WARM_N    = K + PIPE_LAT;

  logic                 clk = 1'b0;
  logic                 reset, ch_enable, restart, sample_valid;
  logic signed [DW-1:0] x_in, filt_y, filt_x, y_out;
  logic                 filt_reset, filt_enable, y_valid, ready;
  logic [1:0]           state;
  logic [7:0]           drop_cnt;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t xq[$];
  exp_t yq[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  bit   mon_x = 1'b0;
  int   acc_n = 0;
  int   y_pushed = 0;
  int   y_seen = 0;

  always #5 clk = ~clk;

  integrator_seq_ctrl #(.K(K), .PIPE_LAT(PIPE_LAT), .RST_CYC(RST_CYC), .DW(DW)) dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .restart(restart),
    .sample_valid(sample_valid), .x_in(x_in), .filt_y(filt_y),
    .filt_reset(filt_reset), .filt_enable(filt_enable), .filt_x(filt_x),
    .y_out(y_out), .y_valid(y_valid), .ready(ready), .state(state),
    .drop_cnt(drop_cnt)
  );

  function automatic logic signed [DW-1:0] fy(int n);
    return DW'(n * 97 - 3000);
  endfunction

  task automatic check_val(string tag, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", tag, k, act, exp);
    end
  endtask

  // Compares filter input and qualified output against the queued entries.
  task automatic monitor();
    if (mon_x) begin
      if (xq.size() > 0 && xq[0].due == k) begin
        check_val("filt_en_acc", filt_enable, 1);
        check_val("filt_x", filt_x, xq[0].val);
        void'(xq.pop_front());
      end else begin
        check_val("filt_en_gap", filt_enable, 0);
      end
    end
    if (yq.size() > 0 && yq[0].due == k) begin
      check_val("y_valid", y_valid, 1);
      check_val("y_out", y_out, yq[0].val);
      void'(yq.pop_front());
    end else begin
      check_val("y_valid_idle", y_valid, 0);
    end
    if (y_valid) y_seen++;
  endtask

  // Advance one cycle; observation happens on the falling edge.
  task automatic step();
    @(negedge clk);
    k++;
    filt_y = fy(k);
    monitor();
  endtask

  task automatic check_reset_vals(string tag);
    check_val({tag, "_state"}, state, 0);
    check_val({tag, "_freset"}, filt_reset, 1);
    check_val({tag, "_fen"}, filt_enable, 0);
    check_val({tag, "_fx"}, filt_x, 0);
    check_val({tag, "_yout"}, y_out, 0);
    check_val({tag, "_yvalid"}, y_valid, 0);
    check_val({tag, "_ready"}, ready, 0);
    check_val({tag, "_drop"}, drop_cnt, 0);
  endtask

  // Walks a whole flush; caller has already stepped into the first FLUSH cycle.
  task automatic flush_check(bit sv);
    for (int i = 0; i < FLUSH_CYC; i++) begin
      check_val("fl_state", state, 1);
      check_val("fl_reset", filt_reset, (i < RST_CYC) ? 1 : 0);
      check_val("fl_enable", filt_enable, (i >= RST_CYC) ? 1 : 0);
      check_val("fl_x", filt_x, 0);
      check_val("fl_ready", ready, 0);
      restart = 1'b0;
      sample_valid = sv;
      x_in = DW'($urandom);
      step();
    end
    sample_valid = 1'b0;
    check_val("fl_to_warm", state, 2);
    check_val("warm_en0", filt_enable, 0);
    acc_n = 0;
  endtask

  // mode 0: every cycle x=1000, 1: every cycle random, 2: alternate, 3: idle
  task automatic drive_samples(int n, int mode);
    for (int i = 0; i < n; i++) begin
      bit sv;
      check_val("wr_state", state, (acc_n >= WARM_N) ? 3 : 2);
      check_val("wr_ready", ready, (acc_n >= WARM_N) ? 1 : 0);
      sv = (mode == 3) ? 1'b0 : (mode == 2) ? ((i % 2) == 0) : 1'b1;
      sample_valid = sv;
      x_in = (mode == 0) ? DW'(1000) : DW'($urandom);
      if (sv) begin
        xq.push_back('{k + 1, int'(x_in)});
        acc_n++;
        if (acc_n >= WARM_N) begin
          yq.push_back('{k + 2, int'(fy(k + 1))});
          y_pushed++;
        end
      end
      step();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ch_enable = 1'b0; restart = 1'b0; sample_valid = 1'b0;
    x_in = '0; filt_y = fy(0);
    step(); step();
    check_reset_vals("rst");

    reset = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    check_val("idle_restart_state", state, 0);
    check_val("idle_restart_freset", filt_reset, 1);

    // Start-up flush with no samples, then warmup and steady run
    ch_enable = 1'b1;
    step();
    flush_check(1'b0);
    check_val("drop_none", drop_cnt, 0);
    mon_x = 1'b1;
    drive_samples(WARM_N, 0);
    drive_samples(20, 1);
    drive_samples(30, 2);
    drive_samples(2, 3);
    check_val("yq_drained", yq.size(), 0);
    check_val("y_count", y_seen, y_pushed);

    // Restart mid-RUN with samples streaming through the flush
    mon_x = 1'b0; restart = 1'b1;
    step();
    flush_check(1'b1);
    check_val("drop_29", drop_cnt, 29);
    mon_x = 1'b1;
    drive_samples(WARM_N - 1, 1);
    check_val("warm_no_y", y_seen, y_pushed);
    drive_samples(6, 1);
    drive_samples(2, 3);
    check_val("yq_drained2", yq.size(), 0);
    check_val("y_count2", y_seen, y_pushed);

    // Repeated flushes drive drop_cnt into saturation
    for (int n = 0; n < 10; n++) begin
      mon_x = 1'b0; restart = 1'b1; sample_valid = 1'b1;
      step();
      flush_check(1'b1);
      check_val("drop_sat", drop_cnt, (29 * (n + 2) > 255) ? 255 : 29 * (n + 2));
    end

    // Restart during FLUSH phase B restarts phase A
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_val("midfl_state", state, 1);
    check_val("midfl_fen", filt_enable, 1);
    restart = 1'b1;
    step();
    flush_check(1'b0);
    check_val("drop_hold", drop_cnt, 255);

    // Disable and restart together during WARMUP: disable wins
    mon_x = 1'b1;
    drive_samples(5, 1);
    drive_samples(1, 3);
    mon_x = 1'b0;
    ch_enable = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    check_val("dis_state", state, 0);
    check_val("dis_freset", filt_reset, 1);
    check_val("dis_fen", filt_enable, 0);
    check_val("dis_ready", ready, 0);
    step();
    check_val("dis_stay", state, 0);

    // Reset mid-FLUSH
    ch_enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check_val("pre_rst_state", state, 1);
    reset = 1'b1;
    step();
    check_reset_vals("rst2");
    reset = 1'b0; ch_enable = 1'b0;
    step();
    check_val("post_rst_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/integrator_seq_ctrl.md
Name: integrator_seq_ctrl

Overview:
- Sequencing controller for one channel's moving-integrator pedestal-recovery filter.
- Owns the filter's reset/enable/data inputs. Flushes the filter's shift-register window with zeros after any (re)start, then gates output validity until the window and pipeline have filled.
- Sits between the channel's sample stream and the filter instance. Its qualified output feeds the self-trigger logic.

Parameters:
- K, 25, filter window depth in samples; must match the filter's configured depth (1..31).
- PIPE_LAT, 3, filter latency in accepted samples from input to settled output.
- RST_CYC, 2, cycles filt_reset is held at the start of a flush.
- DW, 16, sample width (signed).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ch_enable  in  1  channel enable from config; level
- restart  in  1  single-cycle request to re-flush and re-warm the filter
- sample_valid  in  1  strobe; x_in is a new sample this cycle
- x_in  in  DW  signed input sample
- filt_y  in  DW  signed output of the filter
- filt_reset  out  1  reset to the filter, registered
- filt_enable  out  1  enable to the filter, registered
- filt_x  out  DW  sample to the filter, registered
- y_out  out  DW  qualified filtered sample
- y_valid  out  1  y_out is valid this cycle
- ready  out  1  high while in RUN
- state  out  2  IDLE=0, FLUSH=1, WARMUP=2, RUN=3
- drop_cnt  out  8  count of samples discarded during FLUSH; saturates at 255

Behaviour:
- Reset values (reset has priority over everything):
  - state=IDLE, filt_reset=1, filt_enable=0, filt_x=0
  - y_out=0, y_valid=0, ready=0, drop_cnt=0
  - internal counter=0
- All outputs are registered.
- IDLE:
  - filt_reset=1, filt_enable=0, filt_x=0, y_valid=0.
  - ch_enable=1 → FLUSH with counter=0.
- FLUSH:
  - Phase A, counter 0..RST_CYC-1: filt_reset=1, filt_enable=0.
  - Phase B, the next K+2 cycles: filt_reset=0, filt_enable=1 every cycle, filt_x=0. This writes zeros through the full window irrespective of sample_valid.
  - Total FLUSH duration is RST_CYC+K+2 cycles, then → WARMUP with counter=0.
  - Any sample_valid during FLUSH is dropped; drop_cnt increments by 1, saturating at 255.
- WARMUP:
  - filt_enable = sample_valid of the previous cycle; filt_x = x_in of the previous cycle, i.e. one register stage.
  - counter increments per accepted sample. When counter reaches K+PIPE_LAT-1 on an accepted sample → RUN next cycle.
  - y_valid=0 throughout.
- RUN:
  - filt_enable/filt_x pass through as in WARMUP; ready=1.
  - y_out <= filt_y and y_valid=1 exactly on the cycle after each cycle in which filt_enable=1. Otherwise y_valid=0 and y_out holds its value.
  - Gaps in sample_valid are allowed; no sample is dropped.
- Exit conditions:
  - ch_enable=0 in any state → IDLE next cycle; y_valid=0 and ready=0 on that cycle.
  - restart=1 while in FLUSH, WARMUP or RUN (with ch_enable=1) → FLUSH, counter=0, phase A restarts. This includes restart during FLUSH itself.
  - restart in IDLE is ignored.
  - Simultaneous ch_enable=0 and restart: ch_enable=0 wins.
- Samples are never reordered or duplicated.
- drop_cnt clears only on reset.

Test Plan:
- reset, then ch_enable=1 with sample_valid idle → state sequence IDLE→FLUSH for 29 cycles (2 with filt_reset=1, then 27 with filt_enable=1 and filt_x=0) → WARMUP. y_valid stays 0.
- After FLUSH, drive sample_valid every cycle with x_in=1000 → RUN is entered the cycle after the 28th accepted sample. From then on y_valid is high each cycle, and y_out = filt_y of the previous cycle.
- In RUN, sample_valid every other cycle → filt_enable and y_valid both toggle at 1/2 rate, with y_valid lagging filt_enable by 1 cycle. Count of accepted samples equals count of y_valid pulses.
- sample_valid held high for the entire 29-cycle FLUSH → drop_cnt=29 and filt_x=0 throughout. 10 further restart-induced flushes with sample_valid high → drop_cnt saturates at 255.
- restart pulse mid-RUN → ready=0 next cycle, state=FLUSH, filt_reset=1 for 2 cycles, and no y_valid until 28 new accepted samples have completed warmup.
- ch_enable=0 and restart asserted on the same cycle during WARMUP → IDLE next cycle with filt_reset=1. Then assert reset mid-FLUSH → all outputs return to reset values on the next cycle.
